inv_mix_columns: RTL and testbench
==================================

# inv_mix_columns

Iterative AES InvMixColumns engine for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and multiplies each 4-byte column by the inverse MixColumns matrix over GF(2^8) with modulus x^8+x^4+x^3+x+1 (0x11B). It processes COLS_PER_CYCLE columns per cycle and holds the result until the downstream stage accepts it. It pairs with the forward mixColumns stage and sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

## Interface
- COLS_PER_CYCLE, 1, columns computed per BUSY cycle; legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a state; registered.
- in_data  in  128  input state; byte i = in_data[127-8i -: 8]; column c = bytes 4c..4c+3, with byte 4c as the row-0 entry.
- out_valid  out  1  out_data holds a completed result; registered.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  result state, same byte and column mapping as in_data; registered.

## Operation
- FSM states are IDLE, BUSY and DONE.
  - IDLE: in_ready=1. On in_valid=1, capture in_data into the source register, clear the column counter col, go to BUSY.
  - BUSY: compute columns col .. col+COLS_PER_CYCLE-1 from the source register and write them into the result register. Then col += COLS_PER_CYCLE.
    - If the updated col = 4, go to DONE.
    - Leave in_ready=0 and ignore in_valid.
  - DONE: out_valid=1 and out_data = result register.
    - On out_ready=1, go to IDLE with out_valid=0 and in_ready=1.
    - in_valid is ignored in DONE; there is no same-cycle drain-and-accept.
- Per column (a0,a1,a2,a3), with "·" denoting GF(2^8) multiplication:
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- GF multiplication uses the xtime chain:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - Form x2, x4, x8 from repeated xtime.
  - 09=x8^x, 0b=x8^x2^x, 0d=x8^x4^x, 0e=x8^x4^x2.
  - All arithmetic is 8-bit XOR; nothing widens and there is no carry.
- The source register is stable from capture until return to IDLE. Columns not yet processed in the result register keep their previous values, but out_valid masks them.
- Reset (rst=0 at a rising edge) takes priority over everything, including mid-BUSY and mid-DONE. Resulting values:
  - state=IDLE, col=0, in_ready=1, out_valid=0
  - out_data=128'h0; source and result registers = 0
  - Any in-flight block is discarded and not reported.
  - An in_valid high in the same cycle as reset is not captured.

## Timing
- Accept edge = T (in_valid & in_ready sampled high). in_ready is low from T+1.
- BUSY lasts N = 4/COLS_PER_CYCLE cycles: 4, 2 or 1.
- out_valid rises after the edge at T+N, i.e. it is first visible in the cycle following N BUSY edges.
- Latency from accept to out_valid is N cycles.
- out_data and out_valid hold indefinitely while out_ready=0.
- A handshake at edge D returns the block to IDLE, with in_ready=1 and out_valid=0 after D. The earliest next accept is at edge D+1.
- Throughput with out_ready tied high is one block per N+2 cycles.
- out_ready asserted outside DONE has no effect.

## Test plan
- Known-answer test, COLS_PER_CYCLE=1: in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6 with out_ready=1.
  - Required: out_data=db135345_f20a225c_01010101_c6c6c6c6.
  - out_valid high exactly 4 cycles after accept; in_ready low for the 5 cycles from accept until the DONE handshake.
- Same vector with COLS_PER_CYCLE=2 and with 4: identical out_data; latency 2 and 1 respectively.
- Round trip: for 1000 random states x, drive the forward mixColumns output of x into this block. Required: out_data == x every time.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid held high carrying a second state (4d7ebdf8 in column 0, zeros elsewhere).
  - During the stall: out_data is stable and in_ready stays 0.
  - After the release: the second state is accepted at the edge after the handshake, and its column 0 result = 2d26314c.
- Reset mid-operation: assert rst=0 during BUSY at col=2, then again during DONE.
  - Required the cycle after each: out_valid=0, out_data=0, in_ready=1.
  - The next block computes correctly with no residue from the aborted block.
- Edge values: all-zero state → all zeros; all-FF state → all FF (each row of the inverse matrix XORs to 01).

Source files
------------

// File: rtl/inv_mix_columns.sv
// Iterative AES InvMixColumns engine: captures a 128-bit state, transforms
// COLS_PER_CYCLE columns per BUSY cycle and holds the result until accepted.
module inv_mix_columns #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [2:0] COL_STEP = 3'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_next_s;
    logic [2:0]   col_r;
    logic [2:0]   col_next_s;
    logic [127:0] src_r;
    logic [127:0] src_next_s;
    logic [127:0] res_r;
    logic [127:0] res_next_s;
    logic         in_ready_r;
    logic         out_valid_r;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // k selects which of x8/x4/x2/x are summed, covering 09, 0b, 0d and 0e
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] a);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {gf_mul(a0, 4'hE) ^ gf_mul(a1, 4'hB) ^ gf_mul(a2, 4'hD) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'hE) ^ gf_mul(a2, 4'hB) ^ gf_mul(a3, 4'hD),
                gf_mul(a0, 4'hD) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'hE) ^ gf_mul(a3, 4'hB),
                gf_mul(a0, 4'hB) ^ gf_mul(a1, 4'hD) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'hE)};
    endfunction

    // Column c occupies bits [127-32c -: 32]; 127-32c is {~c, 5'b11111}
    function automatic logic [6:0] col_msb(input logic [1:0] c);
        return {~c, 5'b11111};
    endfunction

    // Next-state, column counter and datapath updates
    always_comb begin
        state_next_s = state_r;
        col_next_s   = col_r;
        src_next_s   = src_r;
        res_next_s   = res_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    src_next_s   = in_data;
                    col_next_s   = 3'd0;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    res_next_s[col_msb(col_r[1:0] + 2'(k)) -: 32] =
                        inv_col(src_r[col_msb(col_r[1:0] + 2'(k)) -: 32]);
                end
                col_next_s = col_r + COL_STEP;
                if (col_next_s == 3'd4) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                col_next_s   = 3'd0;
            end
        endcase
    end

    // State, data and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            col_r       <= 3'd0;
            src_r       <= 128'h0;
            res_r       <= 128'h0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            col_r       <= col_next_s;
            src_r       <= src_next_s;
            res_r       <= res_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = res_r;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Scoreboard bench for inv_mix_columns with one instance per legal column rate.
module tb_inv_mix_columns;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv  [3];
    logic         ir  [3];
    logic [127:0] ind [3];
    logic         ov  [3];
    logic         orr [3];
    logic [127:0] od  [3];

    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] sb_q[$];

    localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] BP_IN   = 128'h4d7ebdf8_00000000_00000000_00000000;
    localparam logic [127:0] BP_OUT  = 128'h2d26314c_00000000_00000000_00000000;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            inv_mix_columns #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (iv[g]),
                .in_ready  (ir[g]),
                .in_data   (ind[g]),
                .out_valid (ov[g]),
                .out_ready (orr[g]),
                .out_data  (od[g])
            );
        end
    endgenerate

    function automatic logic [7:0] m2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Forward MixColumns, used to build states whose inverse is known
    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
            r[103 - 32*c -: 8] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send_and_check(input int d, input logic [127:0] x, input logic [127:0] e,
                                  input int lat_exp, input string name);
        int           wait_n;
        bit           ir_hi;
        logic [127:0] exp_v;
        @(negedge clk);
        wait_n = 0;
        while (ir[d] !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        n_vec++;
        if (ir[d] !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready_before_accept got %b want 1", name, ir[d]);
        end
        iv[d] = 1'b1; ind[d] = x; orr[d] = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        iv[d] = 1'b0;
        wait_n = 0; ir_hi = 1'b0;
        while (ov[d] !== 1'b1 && wait_n < 20) begin
            if (ir[d] !== 1'b0) ir_hi = 1'b1;
            @(negedge clk);
            wait_n++;
        end
        if (ir[d] !== 1'b0) ir_hi = 1'b1;
        n_vec++;
        if (wait_n !== lat_exp) begin
            n_err++;
            $display("FAIL %s latency got %0d want %0d", name, wait_n, lat_exp);
        end
        n_vec++;
        if (ir_hi !== 1'b0) begin
            n_err++;
            $display("FAIL %s in_ready_while_busy got 1 want 0", name);
        end
        exp_v = sb_q.pop_front();
        n_vec++;
        if (od[d] !== exp_v) begin
            n_err++;
            $display("FAIL %s out_data got %h want %h", name, od[d], exp_v);
        end
        @(negedge clk);
        n_vec++;
        if ({ov[d], ir[d]} !== 2'b01) begin
            n_err++;
            $display("FAIL %s after_handshake out_valid/in_ready got %b%b want 01", name, ov[d], ir[d]);
        end
    endtask

    task automatic check_idle_zero(input string name);
        n_vec++;
        if ({ir[0], ov[0], od[0]} !== {1'b1, 1'b0, 128'h0}) begin
            n_err++;
            $display("FAIL %s in_ready=%b out_valid=%b out_data=%h want 1 0 0", name, ir[0], ov[0], od[0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ind[d] = 128'h0; orr[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if ({ir[d], ov[d], od[d]} !== {1'b1, 1'b0, 128'h0}) begin
                n_err++;
                $display("FAIL reset dut%0d in_ready=%b out_valid=%b out_data=%h want 1 0 0", d, ir[d], ov[d], od[d]);
            end
        end
    endtask

    task automatic test_known_answer();
        for (int d = 0; d < 3; d++) send_and_check(d, KAT_IN, KAT_OUT, 4 >> d, $sformatf("kat_cols%0d", 1 << d));
    endtask

    task automatic test_edges();
        send_and_check(0, 128'h0, 128'h0, 4, "all_zero");
        send_and_check(0, {128{1'b1}}, {128{1'b1}}, 4, "all_ff");
        send_and_check(2, {128{1'b1}}, {128{1'b1}}, 1, "all_ff_cols4");
    endtask

    task automatic test_backpressure();
        int           wait_n;
        logic [127:0] exp_v;
        @(negedge clk);
        iv[0] = 1'b1; ind[0] = KAT_IN; orr[0] = 1'b0;
        sb_q.push_back(KAT_OUT);
        @(negedge clk);
        iv[0] = 1'b0;
        wait_n = 0;
        while (ov[0] !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        exp_v = sb_q.pop_front();
        iv[0] = 1'b1; ind[0] = BP_IN;
        sb_q.push_back(BP_OUT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ov[0], ir[0], od[0]} !== {1'b1, 1'b0, exp_v}) begin
                n_err++;
                $display("FAIL stall cycle %0d out_valid=%b in_ready=%b out_data=%h want 1 0 %h", i, ov[0], ir[0], od[0], exp_v);
            end
        end
        orr[0] = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({ov[0], ir[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL release out_valid/in_ready got %b%b want 01", ov[0], ir[0]);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        n_vec++;
        if (ir[0] !== 1'b0) begin
            n_err++;
            $display("FAIL second_accept in_ready got %b want 0", ir[0]);
        end
        wait_n = 0;
        while (ov[0] !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        n_vec++;
        if (wait_n !== 4) begin
            n_err++;
            $display("FAIL second_latency got %0d want 4", wait_n);
        end
        exp_v = sb_q.pop_front();
        n_vec++;
        if (od[0] !== exp_v) begin
            n_err++;
            $display("FAIL second_data got %h want %h", od[0], exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [127:0] y;
        int           wait_n;
        orr[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b1; ind[0] = fwd_mix(rand_state());
        repeat (3) begin
            @(negedge clk);
            iv[0] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_idle_zero("reset_in_busy");
        y = rand_state();
        send_and_check(0, fwd_mix(y), y, 4, "after_busy_reset");

        orr[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b1; ind[0] = fwd_mix(rand_state());
        @(negedge clk);
        iv[0] = 1'b0;
        wait_n = 0;
        while (ov[0] !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        n_vec++;
        if (ov[0] !== 1'b1) begin
            n_err++;
            $display("FAIL reach_done out_valid got %b want 1", ov[0]);
        end
        rst = 1'b0; iv[0] = 1'b1; ind[0] = rand_state();
        @(negedge clk);
        rst = 1'b1; iv[0] = 1'b0;
        check_idle_zero("reset_in_done");
        y = rand_state();
        send_and_check(0, fwd_mix(y), y, 4, "after_done_reset");
    endtask

    task automatic test_round_trip();
        logic [127:0] x;
        for (int i = 0; i < 1000; i++) begin
            x = rand_state();
            send_and_check(i % 3, fwd_mix(x), x, 4 >> (i % 3), "round_trip");
        end
    endtask

    initial begin
        test_reset();
        test_known_answer();
        test_edges();
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
